// File: rtl/friscv_proc_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : friscv_proc_scheduler
// Brief    : Issue controller between decode and the ALU / memfy units.
//            Steers one decoded instruction per cycle, stalls RAW/WAW hazards
//            through a 32-entry scoreboard, bounds outstanding memory ops and
//            drains both units on FENCE.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module friscv_proc_scheduler #(
  parameter int XLEN     = 32,
  parameter int MAX_OUTS = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       inst_en,
  output logic       inst_ready,
  input  logic [1:0] inst_class,
  input  logic [4:0] inst_rs1,
  input  logic [4:0] inst_rs2,
  input  logic [4:0] inst_rd,
  input  logic       inst_rd_wr,
  output logic       alu_en,
  input  logic       alu_ready,
  input  logic       alu_empty,
  input  logic       alu_rd_wr,
  input  logic [4:0] alu_rd_addr,
  output logic       memfy_en,
  input  logic       memfy_ready,
  input  logic       memfy_empty,
  input  logic       memfy_done,
  input  logic       memfy_rd_wr,
  input  logic [4:0] memfy_rd_addr,
  output logic       sched_busy,
  output logic       illegal_err,
  output logic [3:0] outs_cnt
);

  localparam logic [1:0] C_CLASS_ALU   = 2'd0;
  localparam logic [1:0] C_CLASS_MEM   = 2'd1;
  localparam logic [1:0] C_CLASS_FENCE = 2'd2;
  localparam logic [1:0] C_CLASS_ILL   = 2'd3;
  localparam logic [3:0] C_MAX_OUTS    = 4'(MAX_OUTS);

  // Reject parameterisations the 4-bit outstanding counter cannot represent.
  if (MAX_OUTS < 1 || MAX_OUTS > 15 || XLEN < 1) begin : g_param_check
    $error("friscv_proc_scheduler: MAX_OUTS must be 1..15 and XLEN positive");
  end

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sb_q, sb_d;
  logic [3:0]  outs_cnt_q, outs_cnt_d;
  logic        illegal_err_q, illegal_err_d;

  logic [31:0] sb_eff;
  logic        hazard;
  logic        accept;
  logic        sb_idle;

  // Hazard lookup against the registered scoreboard; x0 can never be pending.
  always_comb begin
    sb_eff = {sb_q[31:1], 1'b0};
    hazard = sb_eff[inst_rs1] | sb_eff[inst_rs2] | (inst_rd_wr & sb_eff[inst_rd]);
  end

  // Per-class acceptance and zero-latency issue strobes.
  always_comb begin
    inst_ready = 1'b0;
    if (aresetn && state_q == ST_RUN) begin
      case (inst_class)
        C_CLASS_ALU:   inst_ready = ~hazard & alu_ready;
        C_CLASS_MEM:   inst_ready = ~hazard & memfy_ready & (outs_cnt_q < C_MAX_OUTS);
        C_CLASS_FENCE: inst_ready = 1'b1;
        default:       inst_ready = 1'b1;
      endcase
    end
    accept   = inst_en & inst_ready;
    alu_en   = accept & (inst_class == C_CLASS_ALU);
    memfy_en = accept & (inst_class == C_CLASS_MEM);
  end

  // Next-state for the drain FSM, scoreboard, outstanding counter and error pulse.
  always_comb begin
    state_d       = state_q;
    sb_d          = sb_q;
    outs_cnt_d    = outs_cnt_q;
    illegal_err_d = 1'b0;
    sb_idle       = (sb_q == 32'd0);

    case (state_q)
      ST_RUN: begin
        if (accept && inst_class == C_CLASS_FENCE) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (alu_empty && memfy_empty && outs_cnt_q == 4'd0 && sb_idle) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Clears are applied after the set so a same-index collision resolves to clear.
    if ((alu_en || memfy_en) && inst_rd_wr && inst_rd != 5'd0) sb_d[inst_rd] = 1'b1;
    if (alu_rd_wr)   sb_d[alu_rd_addr]   = 1'b0;
    if (memfy_rd_wr) sb_d[memfy_rd_addr] = 1'b0;
    sb_d[0] = 1'b0;

    // A completion with nothing outstanding is a stray pulse and is ignored.
    if (memfy_en && !(memfy_done && outs_cnt_q != 4'd0)) begin
      outs_cnt_d = outs_cnt_q + 4'd1;
    end else if (!memfy_en && memfy_done && outs_cnt_q != 4'd0) begin
      outs_cnt_d = outs_cnt_q - 4'd1;
    end

    illegal_err_d = accept & (inst_class == C_CLASS_ILL);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_RUN;
      sb_q          <= 32'd0;
      outs_cnt_q    <= 4'd0;
      illegal_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sb_q          <= sb_d;
      outs_cnt_q    <= outs_cnt_d;
      illegal_err_q <= illegal_err_d;
    end
  end

  assign sched_busy  = (state_q == ST_DRAIN);
  assign illegal_err = illegal_err_q;
  assign outs_cnt    = outs_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_friscv_proc_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_friscv_proc_scheduler
// Brief    : Self-checking bench for friscv_proc_scheduler: directed scenarios
//            with literal expectations plus randomized traffic compared every
//            cycle against a behavioural model of the issue rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_friscv_proc_scheduler;

  localparam int MAX_OUTS = 4;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       inst_en;
  logic       inst_ready;
  logic [1:0] inst_class;
  logic [4:0] inst_rs1, inst_rs2, inst_rd;
  logic       inst_rd_wr;
  logic       alu_en, alu_ready, alu_empty, alu_rd_wr;
  logic [4:0] alu_rd_addr;
  logic       memfy_en, memfy_ready, memfy_empty, memfy_done, memfy_rd_wr;
  logic [4:0] memfy_rd_addr;
  logic       sched_busy, illegal_err;
  logic [3:0] outs_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pending-register flags, outstanding count, drain flag.
  bit sb_m [32];
  int outs_m  = 0;
  bit drain_m = 1'b0;
  bit ill_m   = 1'b0;
  bit nx_sb [32];
  int nx_outs  = 0;
  bit nx_drain = 1'b0;
  bit nx_ill   = 1'b0;
  bit e_rdy, e_alu, e_mem, haz;

  always #5 clk = ~clk;

  friscv_proc_scheduler #(.XLEN(32), .MAX_OUTS(MAX_OUTS)) dut (
    .aclk(clk), .aresetn(aresetn),
    .inst_en(inst_en), .inst_ready(inst_ready), .inst_class(inst_class),
    .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .inst_rd(inst_rd), .inst_rd_wr(inst_rd_wr),
    .alu_en(alu_en), .alu_ready(alu_ready), .alu_empty(alu_empty),
    .alu_rd_wr(alu_rd_wr), .alu_rd_addr(alu_rd_addr),
    .memfy_en(memfy_en), .memfy_ready(memfy_ready), .memfy_empty(memfy_empty),
    .memfy_done(memfy_done), .memfy_rd_wr(memfy_rd_wr), .memfy_rd_addr(memfy_rd_addr),
    .sched_busy(sched_busy), .illegal_err(illegal_err), .outs_cnt(outs_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < 32; i++) if (sb_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Model evaluation and per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!aresetn) begin
      e_rdy = 1'b0; e_alu = 1'b0; e_mem = 1'b0;
      for (int i = 0; i < 32; i++) nx_sb[i] = 1'b0;
      nx_outs = 0; nx_drain = 1'b0; nx_ill = 1'b0;
    end else begin
      haz = (inst_rd_wr && inst_rd != 0 && sb_m[inst_rd]) ||
            (inst_rs1 != 0 && sb_m[inst_rs1]) || (inst_rs2 != 0 && sb_m[inst_rs2]);
      if (drain_m)                e_rdy = 1'b0;
      else if (inst_class == 2'd0) e_rdy = !haz && alu_ready;
      else if (inst_class == 2'd1) e_rdy = !haz && memfy_ready && (outs_m < MAX_OUTS);
      else                         e_rdy = 1'b1;
      e_alu = inst_en && e_rdy && inst_class == 2'd0;
      e_mem = inst_en && e_rdy && inst_class == 2'd1;
      nx_sb = sb_m;
      if ((e_alu || e_mem) && inst_rd_wr && inst_rd != 0) nx_sb[inst_rd] = 1'b1;
      if (alu_rd_wr)   nx_sb[alu_rd_addr]   = 1'b0;
      if (memfy_rd_wr) nx_sb[memfy_rd_addr] = 1'b0;
      nx_outs = outs_m + (e_mem ? 1 : 0) - ((memfy_done && outs_m > 0) ? 1 : 0);
      if (drain_m) nx_drain = !(alu_empty && memfy_empty && outs_m == 0 && !any_pending());
      else         nx_drain = inst_en && e_rdy && inst_class == 2'd2;
      nx_ill = inst_en && e_rdy && inst_class == 2'd3;
    end
    chk("model_inst_ready",  32'(inst_ready),  32'(e_rdy));
    chk("model_alu_en",      32'(alu_en),      32'(e_alu));
    chk("model_memfy_en",    32'(memfy_en),    32'(e_mem));
    chk("model_sched_busy",  32'(sched_busy),  32'(drain_m));
    chk("model_illegal_err", 32'(illegal_err), 32'(ill_m));
    chk("model_outs_cnt",    32'(outs_cnt),    32'(outs_m));
  end

  // Model state advances on the same edge as the design.
  always @(posedge clk) begin
    sb_m = nx_sb; outs_m = nx_outs; drain_m = nx_drain; ill_m = nx_ill;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_en = 1'b0; inst_class = 2'd0; inst_rs1 = 5'd0; inst_rs2 = 5'd0;
    inst_rd = 5'd0; inst_rd_wr = 1'b0;
    alu_rd_wr = 1'b0; alu_rd_addr = 5'd0;
    memfy_rd_wr = 1'b0; memfy_rd_addr = 5'd0; memfy_done = 1'b0;
  endtask

  task automatic put(input logic [1:0] c, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic w);
    idle();
    inst_en = 1'b1; inst_class = c; inst_rs1 = s1; inst_rs2 = s2; inst_rd = d; inst_rd_wr = w;
  endtask

  // Retire everything outstanding and release every scoreboard entry.
  task automatic cleanup();
    for (int i = 0; i < 15; i++) begin tick(); idle(); memfy_done = 1'b1; end
    for (int r = 1; r < 32; r++) begin tick(); idle(); memfy_rd_wr = 1'b1; memfy_rd_addr = 5'(r); end
    tick(); idle();
  endtask

  initial begin
    aresetn = 1'b0;
    alu_ready = 1'b1; memfy_ready = 1'b1; alu_empty = 1'b1; memfy_empty = 1'b1;
    idle();
    inst_en = 1'b1;

    // Reset holds handshakes low.
    repeat (2) tick();
    #1;
    chk("rst_inst_ready", 32'(inst_ready), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_outs_cnt", 32'(outs_cnt), 32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    tick(); aresetn = 1'b1; put(2'd0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("post_rst_ready", 32'(inst_ready), 32'd1);

    // RAW: producer x5, consumer stalls until the cycle after writeback.
    tick(); put(2'd0, 5'd0, 5'd0, 5'd5, 1'b1); #1;
    chk("raw_first_issue", 32'(alu_en), 32'd1);
    tick(); put(2'd0, 5'd5, 5'd0, 5'd6, 1'b1); #1;
    chk("raw_stall_c2", 32'(inst_ready), 32'd0);
    tick(); alu_rd_wr = 1'b1; alu_rd_addr = 5'd5; #1;
    chk("raw_stall_c3", 32'(inst_ready), 32'd0);
    tick(); alu_rd_wr = 1'b0; #1;
    chk("raw_issue_c4", 32'(alu_en), 32'd1);
    tick(); idle(); alu_rd_wr = 1'b1; alu_rd_addr = 5'd6;
    tick(); idle();

    // Outstanding limit: 4 loads issue, the 5th waits for a completion.
    for (int i = 1; i <= 5; i++) begin
      tick(); put(2'd1, 5'd0, 5'd0, 5'(i), 1'b1); #1;
      if (i <= 4) chk("load_issue", 32'(memfy_en), 32'd1);
      else        chk("load5_stall", 32'(inst_ready), 32'd0);
    end
    chk("outs_at_max", 32'(outs_cnt), 32'd4);
    tick(); memfy_done = 1'b1; #1;
    chk("load5_stall_done", 32'(inst_ready), 32'd0);
    tick(); memfy_done = 1'b0; #1;
    chk("load5_issue", 32'(memfy_en), 32'd1);
    chk("outs_after_done", 32'(outs_cnt), 32'd3);
    tick(); idle(); #1;
    chk("outs_refill", 32'(outs_cnt), 32'd4);
    cleanup();

    // x0 destination never creates a hazard.
    tick(); put(2'd1, 5'd0, 5'd0, 5'd0, 1'b1); #1;
    chk("x0_load_issue", 32'(memfy_en), 32'd1);
    tick(); put(2'd0, 5'd0, 5'd0, 5'd7, 1'b0); #1;
    chk("x0_no_stall", 32'(alu_en), 32'd1);
    cleanup();

    // Issue and completion in the same cycle leave the count unchanged.
    tick(); put(2'd1, 5'd0, 5'd0, 5'd0, 1'b0);
    tick(); put(2'd1, 5'd0, 5'd0, 5'd0, 1'b0);
    tick(); put(2'd1, 5'd0, 5'd0, 5'd0, 1'b0); memfy_done = 1'b1; #1;
    chk("outs_before_both", 32'(outs_cnt), 32'd2);
    tick(); idle(); #1;
    chk("outs_en_and_done", 32'(outs_cnt), 32'd2);
    cleanup();

    // FENCE with two loads pending drains before new work is accepted.
    tick(); put(2'd1, 5'd0, 5'd0, 5'd6, 1'b1);
    tick(); put(2'd1, 5'd0, 5'd0, 5'd7, 1'b1);
    tick(); put(2'd2, 5'd0, 5'd0, 5'd0, 1'b0); memfy_empty = 1'b0; #1;
    chk("fence_accept", 32'(inst_ready), 32'd1);
    tick(); put(2'd0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("fence_busy", 32'(sched_busy), 32'd1);
    chk("fence_blocks", 32'(inst_ready), 32'd0);
    tick(); memfy_done = 1'b1;
    tick(); memfy_done = 1'b1;
    tick(); memfy_done = 1'b0; memfy_rd_wr = 1'b1; memfy_rd_addr = 5'd6;
    alu_rd_wr = 1'b1; alu_rd_addr = 5'd7; #1;
    chk("fence_busy_wb", 32'(sched_busy), 32'd1);
    tick(); memfy_rd_wr = 1'b0; alu_rd_wr = 1'b0; #1;
    chk("fence_busy_not_empty", 32'(sched_busy), 32'd1);
    memfy_empty = 1'b1;
    tick(); #1;
    chk("fence_exit_busy", 32'(sched_busy), 32'd0);
    chk("fence_exit_ready", 32'(inst_ready), 32'd1);
    tick(); idle();

    // Illegal class is swallowed and reported for exactly one cycle.
    tick(); put(2'd3, 5'd0, 5'd0, 5'd3, 1'b1); #1;
    chk("ill_ready", 32'(inst_ready), 32'd1);
    chk("ill_no_issue", 32'({alu_en, memfy_en}), 32'd0);
    tick(); idle(); #1;
    chk("ill_pulse", 32'(illegal_err), 32'd1);
    tick(); #1;
    chk("ill_pulse_end", 32'(illegal_err), 32'd0);

    // Reset in the middle of a drain returns straight to RUN.
    tick(); put(2'd1, 5'd0, 5'd0, 5'd9, 1'b1);
    tick(); put(2'd2, 5'd0, 5'd0, 5'd0, 1'b0);
    tick(); idle(); #1;
    chk("drain_before_rst", 32'(sched_busy), 32'd1);
    aresetn = 1'b0;
    tick(); tick(); aresetn = 1'b1; put(2'd0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("rst_drain_busy", 32'(sched_busy), 32'd0);
    chk("rst_drain_outs", 32'(outs_cnt), 32'd0);
    chk("rst_drain_ready", 32'(inst_ready), 32'd1);

    // Randomized traffic; writebacks favour currently pending registers.
    for (int c = 0; c < 4000; c++) begin
      int k, j;
      tick();
      aresetn     = ($urandom_range(0, 299) != 0);
      inst_en     = ($urandom_range(0, 9) < 7);
      k           = $urandom_range(0, 19);
      inst_class  = (k < 9) ? 2'd0 : (k < 17) ? 2'd1 : (k < 18) ? 2'd2 : 2'd3;
      inst_rs1    = 5'($urandom_range(0, 15));
      inst_rs2    = 5'($urandom_range(0, 15));
      inst_rd     = 5'($urandom_range(0, 15));
      inst_rd_wr  = 1'($urandom_range(0, 1));
      alu_ready   = ($urandom_range(0, 4) != 0);
      memfy_ready = ($urandom_range(0, 4) != 0);
      alu_empty   = ($urandom_range(0, 3) != 0);
      memfy_empty = ($urandom_range(0, 3) != 0);
      memfy_done  = ($urandom_range(0, 2) == 0);
      j = $urandom_range(0, 15);
      alu_rd_addr = 5'(j);
      alu_rd_wr   = sb_m[j] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      j = $urandom_range(0, 15);
      memfy_rd_addr = 5'(j);
      memfy_rd_wr   = sb_m[j] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
    end
    tick(); idle(); aresetn = 1'b1;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
